rx_port: RTL and testbench

Per-port receive buffer and grant requester for the switch fabric. It accepts packets from the external input, queues them in a small FIFO, and presents the head packet and a valid flag to every tx_port arbiter. It collects the per-destination grants, which may arrive over several cycles for multicast packets, and pops the head only when every targeted tx_port has granted it.

---
 rtl/switch_defs.sv | 16 +
 rtl/rx_fifo.sv | 56 +++++
 rtl/rx_port.sv | 102 ++++++++++
 tb/tb_rx_port.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/switch_defs.sv
// Shared switch-fabric definitions: port count, packet format and common widths.
`ifndef NUM_PORTS
`define NUM_PORTS 4
`endif

package switch_defs;

    localparam int unsigned PTR_W      = 2;
    localparam int unsigned DROP_CNT_W = 16;

    typedef struct packed {
        logic [7:0]            data;
        logic [`NUM_PORTS-1:0] target;
    } packet_t;

endpackage

// File: rtl/rx_fifo.sv
// Packet FIFO with synchronous write and a combinational view of the head entry.
module rx_fifo
    import switch_defs::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  packet_t                din,
    output packet_t                head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rx_fifo DEPTH must be a power of 2 and at least 2");
    end

    packet_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == DEPTH_C);
    assign count = cnt;

endmodule

// File: rtl/rx_port.sv
// Per-port receive buffer and multicast grant collector.
// Optional self-target filtering at enqueue is enabled by RX_PORT_FILTER_SELF_EN.
module rx_port
    import switch_defs::*;
#(
    parameter int unsigned PORT_ID = 0,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  packet_t               pkt_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [`NUM_PORTS-1:0] grants_in,
    output packet_t               pkt_out,
    output logic                  valid_out,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    if (PORT_ID >= `NUM_PORTS) begin : g_bad_port_id
        $error("rx_port PORT_ID must be below NUM_PORTS");
    end

    logic [`NUM_PORTS-1:0] eff_tgt;
    logic [`NUM_PORTS-1:0] served;
    logic [`NUM_PORTS-1:0] pending;
    packet_t               din;
    packet_t               head;
    logic                  empty;
    logic                  full;
    logic [CW-1:0]         count;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  done;

`ifdef RX_PORT_FILTER_SELF_EN
    localparam logic [`NUM_PORTS-1:0] SELF_MASK = (`NUM_PORTS)'(1) << PORT_ID;
    assign eff_tgt = pkt_in.target & ~SELF_MASK;
`else
    assign eff_tgt = pkt_in.target;
`endif

    always_comb begin
        din        = pkt_in;
        din.target = eff_tgt;
    end

    assign ready_out = (count < DEPTH_C);
    assign accept    = valid_in && ready_out;
    assign push      = accept && (|eff_tgt) && !full;

    assign pending   = head.target & ~served;
    assign valid_out = !empty && (|pending);
    assign done      = ~|(pending & ~grants_in);
    assign pop       = valid_out && done;

    always_comb begin
        pkt_out = '0;
        if (valid_out) begin
            pkt_out        = head;
            pkt_out.target = pending;
        end
    end

    // Grants outside the pending set are masked so stale or spurious grants never stick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            served <= '0;
        end else if (pop) begin
            served <= '0;
        end else if (valid_out) begin
            served <= served | (grants_in & pending);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (accept && !(|eff_tgt) && !(&drop_cnt)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    rx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .din  (din),
        .head (head),
        .empty(empty),
        .full (full),
        .count(count)
    );

endmodule

// File: tb/tb_rx_port.sv
// Directed bench for rx_port with a queue-based model of remaining destinations.
module tb_rx_port;
    import switch_defs::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PORT_ID = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    packet_t     pkt_in = '0;
    logic        valid_in = 1'b0;
    logic [3:0]  grants_in = 4'b0;
    logic        ready_out;
    packet_t     pkt_out;
    logic        valid_out;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: each queued entry holds the destinations still owed a copy.
    packet_t     q[$];
    int unsigned m_drop = 0;

    rx_port #(
        .PORT_ID(PORT_ID),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pkt_in   (pkt_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .grants_in(grants_in),
        .pkt_out  (pkt_out),
        .valid_out(valid_out),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic packet_t mk(input logic [7:0] d, input logic [3:0] t);
        packet_t p;
        p.data   = d;
        p.target = t;
        return p;
    endfunction

    function automatic logic [3:0] filt(input logic [3:0] t);
        logic [3:0] self_bit;
        self_bit = 4'b0001 << PORT_ID;
`ifdef RX_PORT_FILTER_SELF_EN
        return t & ~self_bit;
`else
        return t | (self_bit & 4'b0000);
`endif
    endfunction

    task automatic model_edge(input logic v, input packet_t p, input logic [3:0] g);
        int      sz;
        packet_t h;
        sz = q.size();
        if (sz > 0) begin
            h = q[0];
            if ((h.target & ~g) == 4'b0) begin
                void'(q.pop_front());
            end else begin
                h.target = h.target & ~g;
                q[0] = h;
            end
        end
        if (v && sz < int'(DEPTH)) begin
            h = p;
            h.target = filt(p.target);
            if (h.target == 4'b0) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                q.push_back(h);
            end
        end
    endtask

    task automatic step(input logic v, input packet_t p, input logic [3:0] g);
        valid_in  = v;
        pkt_in    = p;
        grants_in = g;
        @(posedge clk);
        if (rst_n) model_edge(v, p, g);
        @(negedge clk);
        valid_in  = 1'b0;
        pkt_in    = '0;
        grants_in = 4'b0;
    endtask

    always @(negedge clk) begin
        packet_t e;
        e = '0;
        if (q.size() > 0) e = q[0];
        chk("valid_out", 32'(valid_out), 32'(q.size() > 0));
        chk("pkt_out", 32'(pkt_out), 32'(e));
        chk("ready_out", 32'(ready_out), 32'(q.size() < int'(DEPTH)));
        chk("drop_cnt", 32'(drop_cnt), m_drop);
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst valid_out", 32'(valid_out), 32'd0);
        chk("rst pkt_out", 32'(pkt_out), 32'd0);
        chk("rst ready_out", 32'(ready_out), 32'd1);
        chk("rst drop_cnt", 32'(drop_cnt), 32'd0);

        // Unicast
        step(1'b1, mk(8'hA1, 4'b0100), 4'b0000);
        chk("uni valid", 32'(valid_out), 32'd1);
        chk("uni target", 32'(pkt_out.target), 32'h4);
        step(1'b0, '0, 4'b0100);
        chk("uni popped", 32'(valid_out), 32'd0);

        // Multicast split with a spurious grant in between
        step(1'b1, mk(8'hA2, 4'b1010), 4'b0000);
        step(1'b0, '0, 4'b0010);
        chk("mc remaining", 32'(pkt_out.target), 32'h8);
        step(1'b0, '0, 4'b0001);
        chk("mc spurious", 32'(pkt_out.target), 32'h8);
        step(1'b0, '0, 4'b1000);
        chk("mc popped", 32'(valid_out), 32'd0);

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            step(1'b1, mk(8'(8'hC0 + i), 4'b0100), 4'b0000);
            if (i == 3) chk("full ready", 32'(ready_out), 32'd0);
        end
        chk("full head", 32'(pkt_out.data), 32'hC0);
        step(1'b0, '0, 4'b0100);
        chk("after pop ready", 32'(ready_out), 32'd1);
        chk("after pop head", 32'(pkt_out.data), 32'hC1);
        repeat (3) step(1'b0, '0, 4'b0100);
        chk("drained", 32'(valid_out), 32'd0);

        // Self-addressed packet
        step(1'b1, mk(8'hD0, 4'b0010), 4'b0000);
`ifdef RX_PORT_FILTER_SELF_EN
        chk("self drop cnt", 32'(drop_cnt), 32'd1);
        chk("self drop valid", 32'(valid_out), 32'd0);
`else
        chk("self kept valid", 32'(valid_out), 32'd1);
        chk("self kept target", 32'(pkt_out.target), 32'h2);
        step(1'b0, '0, 4'b0010);
        chk("self popped", 32'(valid_out), 32'd0);
`endif

        // Streaming with immediate grants; pointers wrap twice
        for (int i = 0; i < 8; i++) begin
            step(1'b1, mk(8'(8'h10 + i), 4'b0100), 4'b0100);
            chk("stream data", 32'(pkt_out.data), 32'(8'h10 + i));
        end
        step(1'b0, '0, 4'b0100);
        chk("stream done", 32'(valid_out), 32'd0);

        // Mid-operation reset with partial multicast service
        for (int i = 0; i < 3; i++) step(1'b1, mk(8'(8'hE0 + i), 4'b1010), 4'b0000);
        step(1'b0, '0, 4'b0010);
        chk("pre-rst partial", 32'(pkt_out.target), 32'h8);
        #2;
        rst_n = 1'b0;
        q.delete();
        m_drop = 0;
        #1;
        chk("mid rst valid", 32'(valid_out), 32'd0);
        chk("mid rst pkt", 32'(pkt_out), 32'd0);
        chk("mid rst ready", 32'(ready_out), 32'd1);
        chk("mid rst drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, mk(8'hB0, 4'b1010), 4'b0000);
        chk("post rst target", 32'(pkt_out.target), 32'hA);
        chk("post rst data", 32'(pkt_out.data), 32'hB0);
        step(1'b0, '0, 4'b1010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
